// File: rtl/cp0_ext.sv
// MIPS-style coprocessor 0 subset: Count/Compare timer, Status/Cause/EPC/BadVAddr,
// interrupt request generation and exception/ERET bookkeeping.
module cp0_ext #(
  parameter int          HWI_NUM      = 5,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VALUE = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_en,
  input  logic [4:0]         write_addr,
  input  logic [31:0]        write_data,
  input  logic [4:0]         read_addr,
  output logic [31:0]        data_out,
  input  logic [HWI_NUM-1:0] interrupt,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic               exc_badvaddr_valid,
  input  logic [31:0]        exc_badvaddr,
  input  logic               eret,
  input  logic               delayslot_flag,
  input  logic [31:0]        current_pc_addr,
  output logic [31:0]        status,
  output logic [31:0]        cause,
  output logic [31:0]        epc,
  output logic               int_req
);

  localparam int             DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;
  localparam logic [4:0] ADDR_CONFIG   = 5'd16;

  logic [31:0]      badvaddr_q, badvaddr_d;
  logic [31:0]      count_q,    count_d;
  logic [31:0]      compare_q,  compare_d;
  logic [DIV_W-1:0] div_q,      div_d;
  logic             timer_q,    timer_d;
  logic [7:0]       im_q,       im_d;
  logic             exl_q,      exl_d;
  logic             ie_q,       ie_d;
  logic             bd_q,       bd_d;
  logic [4:0]       exccode_q,  exccode_d;
  logic             ip_tim_q,   ip_tim_d;
  logic [4:0]       ip_hw_q,    ip_hw_d;
  logic [1:0]       ip_sw_q,    ip_sw_d;
  logic [31:0]      epc_q,      epc_d;
  logic             int_req_q,  int_req_d;

  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [4:0]  hw_lines;
  logic [7:0]  cause_ip;
  logic [31:0] status_val, cause_val;
  logic [31:0] read_val;

  assign wr_count   = write_en && (write_addr == ADDR_COUNT);
  assign wr_compare = write_en && (write_addr == ADDR_COMPARE);
  assign wr_status  = write_en && (write_addr == ADDR_STATUS);
  assign wr_cause   = write_en && (write_addr == ADDR_CAUSE);
  assign wr_epc     = write_en && (write_addr == ADDR_EPC);

  // Hardware line i lands in IP[2+i] (Cause[10+i]); missing lines read as 0.
  always_comb begin
    hw_lines = '0;
    for (int i = 0; i < HWI_NUM; i++) hw_lines[i] = interrupt[i];
  end

  assign cause_ip   = {ip_tim_q, ip_hw_q, ip_sw_q};
  assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_val  = {bd_q, timer_q, 14'b0, cause_ip, 1'b0, exccode_q, 2'b0};

  always_comb begin
    count_d = count_q;
    div_d   = div_q;
    if (wr_count) begin
      count_d = write_data;
      div_d   = '0;
    end else if (div_q == DIV_LAST) begin
      count_d = count_q + 32'd1;
      div_d   = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // A Compare write both reloads Compare and acknowledges the timer, beating a new match.
  always_comb begin
    compare_d = wr_compare ? write_data : compare_q;
    timer_d   = timer_q;
    if ((count_q == compare_q) && (compare_q != 32'd0)) timer_d = 1'b1;
    if (wr_compare) timer_d = 1'b0;
  end

  always_comb begin
    im_d       = wr_status ? write_data[15:8] : im_q;
    ie_d       = wr_status ? write_data[0]    : ie_q;
    exl_d      = wr_status ? write_data[1]    : exl_q;
    ip_sw_d    = wr_cause  ? write_data[9:8]  : ip_sw_q;
    ip_hw_d    = hw_lines;
    ip_tim_d   = timer_q;
    epc_d      = wr_epc ? write_data : epc_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    badvaddr_d = badvaddr_q;
    if (exc_valid) begin
      exccode_d = exc_code;
      exl_d     = 1'b1;
      if (exc_badvaddr_valid) badvaddr_d = exc_badvaddr;
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        bd_d  = delayslot_flag;
        epc_d = delayslot_flag ? (current_pc_addr - 32'd4) : current_pc_addr;
      end
    end else if (eret) begin
      exl_d = 1'b0;
    end
  end

  assign int_req_d = ie_q & ~exl_q & (|(cause_ip & im_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      div_q      <= '0;
      timer_q    <= 1'b0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      ip_tim_q   <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      epc_q      <= '0;
      int_req_q  <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      div_q      <= div_d;
      timer_q    <= timer_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_tim_q   <= ip_tim_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      epc_q      <= epc_d;
      int_req_q  <= int_req_d;
    end
  end

  always_comb begin
    read_val = '0;
    case (read_addr)
      ADDR_BADVADDR: read_val = badvaddr_q;
      ADDR_COUNT:    read_val = count_q;
      ADDR_COMPARE:  read_val = compare_q;
      ADDR_STATUS:   read_val = status_val;
      ADDR_CAUSE:    read_val = cause_val;
      ADDR_EPC:      read_val = epc_q;
      ADDR_PRID:     read_val = PRID_VALUE;
      ADDR_CONFIG:   read_val = CONFIG_VALUE;
      default:       read_val = '0;
    endcase
  end

  // Visible outputs are held at zero for as long as reset is asserted.
  assign data_out = rst ? read_val   : 32'd0;
  assign status   = rst ? status_val : 32'd0;
  assign cause    = rst ? cause_val  : 32'd0;
  assign epc      = rst ? epc_q      : 32'd0;
  assign int_req  = int_req_q;

endmodule
